pattern_stamper: RTL
====================

PATTERN_STAMPER -- requirements
Module: pattern_stamper

Interface
REQ-001 Parameter BOARD_W, default 128: board width in cells; power of two, >= 32.
REQ-002 Parameter BOARD_H, default 128: board height in cells; power of two, >= 8.
REQ-003 Parameter WORD_W, default 16: cells per buffer word; power of two.
REQ-004 clk_in  input  1  single clock.
REQ-005 rst_in  input  1  synchronous, active-low reset (low = reset).
REQ-006 start_in  input  1  stamp request; sampled only in IDLE.
REQ-007 pat_sel_in  input  2  pattern select: 0 cell, 1 blinker, 2 block, 3 glider.
REQ-008 mode_in  input  1  0 = OR (set cells), 1 = XOR (toggle cells).
REQ-009 cursor_x_in / cursor_y_in  input  log2(BOARD_W) / log2(BOARD_H)  stamp origin, top-left of 5x5 pattern.
REQ-010 data_r_in  input  WORD_W  read data; valid one cycle after addr_r_out.
REQ-011 addr_r_out / addr_w_out  output  log2(BOARD_W*BOARD_H/WORD_W)  word address = y*(BOARD_W/WORD_W) + x/WORD_W.
REQ-012 data_w_out  output  WORD_W  write data; wr_en_out  output  1  write strobe.
REQ-013 busy_out  output  1  high in every state except IDLE; done_out  output  1  one-cycle completion pulse.

Function
REQ-014 Pattern ROM, 5 rows, bit c = column c: cell r0=0x01; blinker r0=0x07; block r0=r1=0x03; glider r0=0x02, r1=0x04, r2=0x07; all other rows 0.
REQ-015 Cell at column c of word maps to data bit c (bit 0 leftmost).
REQ-016 On accepting start_in, latch cursor, pat_sel, mode; later input changes have no effect until next start.
REQ-017 Per row r: mask = ROM[r] << (x mod WORD_W) in 20-bit field; low WORD_W bits go to word A, bits above to word B.
REQ-018 Straddle = (x mod WORD_W) > WORD_W-5; word B processed only when straddle, independent of pattern contents.
REQ-019 Word A address uses column x; word B uses column (x+WORD_W) mod BOARD_W; row is (y+r) mod BOARD_H (toroidal wrap both axes).
REQ-020 FSM: IDLE -> RD_A -> WR_A -> [RD_B -> WR_B if straddle] -> next row RD_A, after row 4 -> DONE -> IDLE.
REQ-021 RD_x: addr_r_out driven, wr_en_out 0; WR_x: wr_en_out 1, addr_w_out = same address, data_w_out = data_r_in | mask (OR) or data_r_in ^ mask (XOR).
REQ-022 All 5 rows processed even with zero mask (unchanged write-back); latency fixed.
REQ-023 Start accepted at edge E0 -> RD_A of row 0 in cycle k=0; done_out high in cycle k=10 (no straddle) or k=20 (straddle); busy_out high k=0..k=10/20 inclusive.
REQ-024 start_in while not IDLE (incl. DONE) ignored, not queued.
REQ-025 Outputs registered or decoded from registered state only; no combinational path start_in -> wr_en_out.

Reset
REQ-026 rst_in low at an edge: state IDLE, busy_out 0, done_out 0, wr_en_out 0, addr_r_out 0, addr_w_out 0, data_w_out 0, latched fields 0.
REQ-027 Reset mid-operation aborts immediately; already written words stay written; no done_out pulse.

Verification
REQ-028 rst_in low 2 cycles, start_in high -> all outputs 0, no start accepted during reset.
REQ-029 Block, OR, x=3, y=10, memory zero -> writes addr 80=0x0018, 88=0x0018, 96/104/112=0x0000; done_out at k=10.
REQ-030 Glider, OR, x=14, y=0, memory zero -> writes (0,0x8000),(1,0x0000),(8,0x0000),(9,0x0001),(16,0xC000),(17,0x0001), rows 3-4 zero; done_out at k=20.
REQ-031 Cell, OR, x=127, y=127 -> row0 writes addr 1023=0x8000 and addr 1016 (B wraps to column 0); rows 1-4 use addrs 7/0, 15/8, 23/16, 31/24; done_out at k=20.
REQ-032 Memory addr 80=0xFFFF, block, XOR, x=0, y=10 -> addr 80 written 0xFFFC, addr 88 per its contents ^ 0x0003.
REQ-033 start_in pulsed at k=3 ignored; rst_in low at k=5 -> wr_en_out 0, busy_out 0 next cycle, no done_out; next start completes normally.

Source files
------------

// File: rtl/pattern_stamper.sv
// pattern_stamper: stamps a 5x5 ROM pattern into a word-organised toroidal board by read-modify-write
module pattern_stamper #(
    parameter int BOARD_W = 128,
    parameter int BOARD_H = 128,
    parameter int WORD_W  = 16
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       start_in,
    input  logic [1:0]                                 pat_sel_in,
    input  logic                                       mode_in,
    input  logic [$clog2(BOARD_W)-1:0]                 cursor_x_in,
    input  logic [$clog2(BOARD_H)-1:0]                 cursor_y_in,
    input  logic [WORD_W-1:0]                          data_r_in,
    output logic [$clog2(BOARD_W*BOARD_H/WORD_W)-1:0]  addr_r_out,
    output logic [$clog2(BOARD_W*BOARD_H/WORD_W)-1:0]  addr_w_out,
    output logic [WORD_W-1:0]                          data_w_out,
    output logic                                       wr_en_out,
    output logic                                       busy_out,
    output logic                                       done_out
);
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam int OW = $clog2(WORD_W);
    localparam int AW = $clog2(BOARD_W*BOARD_H/WORD_W);
    localparam logic [OW-1:0] STR_LIM = OW'(WORD_W-5);

    typedef enum logic [2:0] {IDLE, RD_A, WR_A, RD_B, WR_B, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        sel_q, sel_d;
    logic              mode_q, mode_d;

    function automatic logic [4:0] rom(input logic [1:0] s, input logic [2:0] r);
        return (s == 2'd0) ? ((r == 3'd0) ? 5'h01 : 5'h00) :
               (s == 2'd1) ? ((r == 3'd0) ? 5'h07 : 5'h00) :
               (s == 2'd2) ? ((r <= 3'd1) ? 5'h03 : 5'h00) :
               (r == 3'd0) ? 5'h02 : (r == 3'd1) ? 5'h04 : (r == 3'd2) ? 5'h07 : 5'h00;
    endfunction

    logic [OW-1:0]       off;
    logic                straddle, is_b, is_rd, is_wr;
    logic [2*WORD_W-1:0] field;
    logic [WORD_W-1:0]   mask;
    logic [XW-1:0]       col;
    logic [YW-1:0]       row_y;
    logic [AW-1:0]       addr;

    assign off      = x_q[OW-1:0];
    assign straddle = off > STR_LIM;
    assign field    = {{(2*WORD_W-5){1'b0}}, rom(sel_q, row_q)} << off;
    assign is_b     = (state_q == RD_B) || (state_q == WR_B);
    assign is_rd    = (state_q == RD_A) || (state_q == RD_B);
    assign is_wr    = (state_q == WR_A) || (state_q == WR_B);
    assign mask     = is_b ? field[2*WORD_W-1:WORD_W] : field[WORD_W-1:0];
    assign col      = is_b ? x_q + XW'(WORD_W) : x_q;
    assign row_y    = y_q + YW'(row_q);
    assign addr     = {row_y, col[XW-1:OW]};

    assign addr_r_out = is_rd ? addr : '0;
    assign addr_w_out = is_wr ? addr : '0;
    assign wr_en_out  = is_wr;
    assign data_w_out = is_wr ? (mode_q ? (data_r_in ^ mask) : (data_r_in | mask)) : '0;
    assign busy_out   = state_q != IDLE;
    assign done_out   = state_q == DONE;

    // next-state: walk rows A then optional B word, latching the request on start
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (start_in) begin
                state_d = RD_A;
                row_d   = 3'd0;
                x_d     = cursor_x_in;
                y_d     = cursor_y_in;
                sel_d   = pat_sel_in;
                mode_d  = mode_in;
            end
            RD_A: state_d = WR_A;
            RD_B: state_d = WR_B;
            WR_A, WR_B: begin
                if (state_q == WR_A && straddle) state_d = RD_B;
                else if (row_q == 3'd4) state_d = DONE;
                else begin
                    state_d = RD_A;
                    row_d   = row_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched request registers, cleared by active-low sync reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
        end
    end
endmodule
